pipemem_lsu: RTL
================

# pipemem_lsu

MEM-stage load/store unit plus MEM/WB pipeline register for the five-stage pipelined CPU. It drives a variable-latency data-memory bus with a req/ack handshake and stalls the pipeline while an access is outstanding. It performs byte/halfword/word alignment and sign/zero extension, and delivers `walu`, `wmo`, `wm2reg`, `wwreg` and `wrn` directly to the WB stage's write-data select.

## Interface
- `MAX_WAIT`, 15: cycles in BUSY without `dm_ack` before the access is aborted as a bus error (range 1–255).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `malu` in 32: ALU result / effective address in MEM.
- `mb` in 32: store data.
- `mrn` in 5: destination register.
- `mwreg` in 1: register write enable.
- `mm2reg` in 1: load.
- `mwmem` in 1: store.
- `msize` in 2: 00 byte, 01 half, 10 word (11 treated as word).
- `msext` in 1: sign-extend loads.
- `dm_req` out 1: access request.
- `dm_we` out 1: store when 1.
- `dm_addr` out 32: word address, `{malu[31:2],2'b00}`.
- `dm_wdata` out 32: store data, lane-replicated.
- `dm_be` out 4: byte enables.
- `dm_ack` in 1: access complete; `dm_rdata` valid in the same cycle.
- `dm_rdata` in 32: read data.
- `mstall` out 1: freeze PC/IF/ID/EXE and the EXE/MEM register.
- `walu` out 32, `wmo` out 32, `wm2reg` out 1, `wwreg` out 1, `wrn` out 5: MEM/WB register outputs.
- `align_err` out 1: one-cycle pulse on a misaligned access.
- `bus_err` out 1: one-cycle pulse on a timeout.

## Operation
- Memory op = `mm2reg|mwmem`. Misaligned = half with `malu[0]`=1, or word with `malu[1:0]`≠0.
- Little-endian lanes: byte n = bits [8n+7:8n], selected by `malu[1:0]`.
- FSM states: IDLE, BUSY.
- IDLE, no memory op:
  - `mstall`=0.
  - MEM/WB loads `{malu, mrn, mwreg, mm2reg=0}`; `wmo` holds.
- IDLE, misaligned memory op:
  - No request; `mstall`=0.
  - `align_err`=1 next cycle.
  - MEM/WB loads a kill (`wwreg`=0, `wm2reg`=0).
- IDLE, aligned memory op:
  - `mstall`=1; MEM/WB loads a bubble (`wwreg`=0, `wm2reg`=0, `wrn`=0, `walu`/`wmo` hold).
  - Registered `dm_req`, `dm_we`, `dm_addr`, `dm_be`, `dm_wdata` load; go BUSY.
  - Wait counter clears.
- Byte enables: byte `4'b0001<<malu[1:0]`; half `4'b0011<<{malu[1],1'b0}`; word `4'b1111`.
- Store data: byte `{4{mb[7:0]}}`; half `{2{mb[15:0]}}`; word `mb`.
- BUSY: request outputs held stable. `dm_req`=1 until ack or abort.
  - With `dm_ack`: `mstall`=0.
    - MEM/WB loads `walu`=`malu`, `wrn`, `wwreg`=`mwreg`, `wm2reg`=`mm2reg`.
    - `wmo` = extracted lane, zero-extended, or sign-extended if `msext`.
    - `dm_req` drops; go IDLE.
  - Without ack, counter < `MAX_WAIT`-1: `mstall`=1, bubble, counter+1.
  - Counter = `MAX_WAIT`-1 and no ack: abort.
    - `dm_req` drops; `bus_err` pulses next cycle.
    - `mstall`=0; MEM/WB loads a kill; go IDLE.
  - An ack in the abort cycle wins: normal completion, no `bus_err`.
- Upstream holds all M-stage inputs constant while `mstall`=1.
- An instruction following a memory op is re-evaluated in IDLE; back-to-back memory ops each pay the issue cycle.
- `dm_ack` is ignored in IDLE.

## Timing
- Reset: state IDLE, counter 0.
  - Outputs all zero: `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `dm_be`, `walu`, `wmo`, `wm2reg`, `wwreg`, `wrn`, `align_err`, `bus_err`.
  - `mstall` is combinational and evaluates to 0 for a non-memory op.
- Reset mid-BUSY: `dm_req` drops asynchronously. No completion, no `bus_err`.
- Non-memory op: 1 cycle in MEM.
- Memory op with ack in the first BUSY cycle: 2 cycles in MEM (1 stall).
  - Ack k cycles after the request: k+2 cycles.
- Timeout: `MAX_WAIT`+1 cycles in MEM.
- `mstall` is combinational from state, counter, `dm_ack` and the M-stage inputs. No combinational path from `dm_rdata` to any output except through the MEM/WB register.

## Test plan
- ALU op: `malu`=0x1234, `mrn`=5, `mwreg`=1, no memory op.
  - Next cycle `walu`=0x1234, `wrn`=5, `wwreg`=1, `wm2reg`=0.
  - `mstall` never 1.
- `lb` with `msext`=1, `malu`=0x103, ack in the first BUSY cycle, `dm_rdata`=0x80FF_0000.
  - `dm_addr`=0x100, `dm_be`=0000 (read).
  - `wmo`=0xFFFF_FF80, `wm2reg`=1.
  - Exactly 1 stall cycle.
- `sh` at `malu`=0x202, `mb`=0xABCD_1234, ack after 3 cycles.
  - `dm_we`=1, `dm_be`=1100, `dm_wdata`=0x1234_1234.
  - 4 stall cycles; `wwreg`=0.
- `lw` at `malu`=0x101.
  - No `dm_req`, `align_err` pulse, `wwreg`=0, `mstall`=0.
- `lw` with `MAX_WAIT`=4 and no ack.
  - `dm_req` high for 4 cycles, then `bus_err` pulse, `wwreg`=0, pipeline resumes.
  - Repeat with ack in the 4th cycle: normal completion, no `bus_err`.
- Assert `rst` during BUSY.
  - `dm_req`=0 immediately and all outputs zero.
  - After release, the next `lhu` (`malu`=0x2, `dm_rdata`=0xFFFE_0000) gives `wmo`=0x0000_FFFE.

Source files
------------

// File: rtl/pipemem_lsu.sv
// MEM-stage load/store unit with MEM/WB register; 1 cycle for ALU ops, k+2 for memory ops acked k cycles after request.
// Stalls upstream via combinational mstall while an access is outstanding; timeout after MAX_WAIT busy cycles.
module pipemem_lsu #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [4:0]  mrn,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [1:0]  msize,
  input  logic        msext,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_be,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mstall,
  output logic [31:0] walu,
  output logic [31:0] wmo,
  output logic        wm2reg,
  output logic        wwreg,
  output logic [4:0]  wrn,
  output logic        align_err,
  output logic        bus_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        memop, misal, timeout;
  logic        issue, done, abort;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic [15:0] lane;
  logic [31:0] ld_data;

  assign memop   = mm2reg | mwmem;
  assign misal   = memop && ((msize == 2'b01 && malu[0]) || (msize[1] && malu[1:0] != 2'b00));
  assign timeout = (cnt == 8'(MAX_WAIT - 1));

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = mb;
    case (msize)
      2'b00: begin
        be_nxt    = 4'b0001 << malu[1:0];
        wdata_nxt = {4{mb[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << {malu[1], 1'b0};
        wdata_nxt = {2{mb[15:0]}};
      end
      default: ;
    endcase
    if (!mwmem) be_nxt = 4'b0000;
  end

  // Aligned halves have malu[0]=0, so the byte shift also selects the half lane.
  always_comb begin
    lane    = 16'(dm_rdata >> {malu[1:0], 3'b000});
    ld_data = dm_rdata;
    case (msize)
      2'b00:   ld_data = msext ? {{24{lane[7]}}, lane[7:0]} : {24'b0, lane[7:0]};
      2'b01:   ld_data = msext ? {{16{lane[15]}}, lane} : {16'b0, lane};
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    mstall    = 1'b0;
    issue     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (memop && !misal) begin
          mstall    = 1'b1;
          issue     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (dm_ack) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (timeout) begin
          abort     = 1'b1;
          state_nxt = IDLE;
        end else begin
          mstall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= 32'd0;
      dm_wdata  <= 32'd0;
      dm_be     <= 4'd0;
      walu      <= 32'd0;
      wmo       <= 32'd0;
      wm2reg    <= 1'b0;
      wwreg     <= 1'b0;
      wrn       <= 5'd0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      align_err <= (state == IDLE) && misal;
      bus_err   <= abort;

      if (issue) begin
        dm_req   <= 1'b1;
        dm_we    <= mwmem;
        dm_addr  <= {malu[31:2], 2'b00};
        dm_be    <= be_nxt;
        dm_wdata <= wdata_nxt;
        cnt      <= 8'd0;
      end else if (done || abort) begin
        dm_req <= 1'b0;
      end else if (state == BUSY) begin
        cnt <= cnt + 8'd1;
      end

      // Bubbles and kills both clear the write controls; walu/wmo hold.
      if (state == IDLE && !memop) begin
        walu   <= malu;
        wrn    <= mrn;
        wwreg  <= mwreg;
        wm2reg <= 1'b0;
      end else if (done) begin
        walu   <= malu;
        wrn    <= mrn;
        wwreg  <= mwreg;
        wm2reg <= mm2reg;
        wmo    <= ld_data;
      end else begin
        wrn    <= 5'd0;
        wwreg  <= 1'b0;
        wm2reg <= 1'b0;
      end
    end
  end

endmodule
